// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VESA-style video timing generator.
// Divides clk_50MHz into a pixel strobe and derives pixel coordinates (stage 0)
// plus registered sync, blanking and DAC colour outputs (stage 1, one pixel later).
// Optional feature macro: TEST_PATTERN_EN adds a test_mode input that replaces
// rgb_in with eight vertical colour bars.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int COLOR_W   = 8,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W      = $clog2(H_TOTAL),
  localparam int V_W      = $clog2(V_TOTAL)
) (
  input  logic                   clk_50MHz,
  input  logic                   clear,
  input  logic                   enable,
`ifdef TEST_PATTERN_EN
  input  logic                   test_mode,
`endif
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic                   clk_25MHz,
  output logic                   pix_tick,
  output logic [H_W-1:0]         x,
  output logic [V_W-1:0]         y,
  output logic                   active,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   sync_n,
  output logic                   blank_n,
  output logic [COLOR_W-1:0]     red_out,
  output logic [COLOR_W-1:0]     green_out,
  output logic [COLOR_W-1:0]     blue_out,
  output logic                   frame_start,
  output logic                   line_start
);

  localparam int DIV_W = $clog2(CLK_DIV);

  // Region boundaries as counter-width constants so every compare is width-matched.
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [H_W-1:0]   H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);

  // Elaboration-time sanity checks on the mode parameters.
  generate
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be even and >= 2");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
  endgenerate

  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [H_W-1:0]         h_cnt_q, h_cnt_d;
  logic [V_W-1:0]         v_cnt_q, v_cnt_d;
  logic                   pclk_q, pclk_d;
  logic                   h_sync_q, h_sync_d;
  logic                   v_sync_q, v_sync_d;
  logic                   blank_n_q, blank_n_d;
  logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
  logic [3*COLOR_W-1:0]   pix_rgb;
  logic                   in_h_sync, in_v_sync;

  // Stage 0: combinational decode of the current counter position.
  assign pix_tick    = enable && (div_cnt_q == DIV_LAST);
  assign active      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign x           = active ? h_cnt_q : '0;
  assign y           = active ? v_cnt_q : '0;
  assign in_h_sync   = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
  assign in_v_sync   = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
  assign frame_start = pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign line_start  = pix_tick && (h_cnt_q == '0) && (v_cnt_q < V_ACT_END);

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0]           bar_idx;
  logic [3*COLOR_W-1:0] bar_rgb;

  // Colour-bar lookup: white, yellow, cyan, green, magenta, red, blue, black.
  // With the bar index b, R = ~b[1], G = ~b[2], B = ~b[0] gives exactly that order.
  always_comb begin
    bar_idx = 3'd7;
    if ((int'(h_cnt_q) / BAR_W) < 8) bar_idx = 3'(int'(h_cnt_q) / BAR_W);
    bar_rgb = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
  end

  assign pix_rgb = test_mode ? bar_rgb : rgb_in;
`else
  assign pix_rgb = rgb_in;
`endif

  // Next-state for divider, pixel/line counters and the stage-1 output registers.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    h_sync_d  = h_sync_q;
    v_sync_d  = v_sync_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;

    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end

    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    if (!enable) begin
      // Sync levels hold; the DAC is blanked while frozen.
      blank_n_d = 1'b0;
      rgb_d     = '0;
    end else if (pix_tick) begin
      h_sync_d  = in_h_sync ? HSYNC_POL : ~HSYNC_POL;
      v_sync_d  = in_v_sync ? VSYNC_POL : ~VSYNC_POL;
      blank_n_d = active;
      rgb_d     = active ? pix_rgb : '0;
    end

    // Pixel clock is high for the upper half of each divider period.
    pclk_d = (div_cnt_d >= DIV_HALF);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pclk_q    <= 1'b0;
      h_sync_q  <= ~HSYNC_POL;
      v_sync_q  <= ~VSYNC_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pclk_q    <= pclk_d;
      h_sync_q  <= h_sync_d;
      v_sync_q  <= v_sync_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign clk_25MHz = pclk_q;
  assign h_sync    = h_sync_q;
  assign v_sync    = v_sync_q;
  assign blank_n   = blank_n_q;
  assign sync_n    = 1'b0;
  assign red_out   = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign green_out = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue_out  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut runs the default 640x480 mode; dut_s runs a tiny 16x8 mode (CLK_DIV=4,
// positive syncs) so that whole-frame behaviour fits in a short run.
module tb_vga_timing_gen;

  logic clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_fail   = 0;

  // Default-mode instance
  logic        clear, enable;
  logic [23:0] rgb_in;
  logic        clk_25MHz, pix_tick, active, h_sync, v_sync, sync_n, blank_n;
  logic        frame_start, line_start;
  logic [9:0]  x, y;
  logic [7:0]  red_out, green_out, blue_out;
`ifdef TEST_PATTERN_EN
  logic        test_mode;
  logic        test_mode_s;
`endif

  // Pixel source model: colour is a function of the requested coordinate.
  assign rgb_in = {x[7:0], y[7:0], 8'hA5};

  vga_timing_gen dut (
    .clk_50MHz  (clk_50MHz),
    .clear      (clear),
    .enable     (enable),
`ifdef TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .rgb_in     (rgb_in),
    .clk_25MHz  (clk_25MHz),
    .pix_tick   (pix_tick),
    .x          (x),
    .y          (y),
    .active     (active),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .sync_n     (sync_n),
    .blank_n    (blank_n),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .frame_start(frame_start),
    .line_start (line_start)
  );

  // Small-mode instance: H 16+2+4+2=24, V 8+1+2+1=12, CLK_DIV=4.
  logic        clear_s, enable_s;
  logic [11:0] rgb_s;
  logic        clk_25_s, pix_tick_s, active_s, h_sync_s, v_sync_s, sync_n_s, blank_n_s;
  logic        frame_start_s, line_start_s;
  logic [4:0]  x_s;
  logic [3:0]  y_s;
  logic [3:0]  red_s, green_s, blue_s;

  assign rgb_s = {x_s[3:0], y_s, 4'h5};

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(4), .COLOR_W(4)
  ) dut_s (
    .clk_50MHz  (clk_50MHz),
    .clear      (clear_s),
    .enable     (enable_s),
`ifdef TEST_PATTERN_EN
    .test_mode  (test_mode_s),
`endif
    .rgb_in     (rgb_s),
    .clk_25MHz  (clk_25_s),
    .pix_tick   (pix_tick_s),
    .x          (x_s),
    .y          (y_s),
    .active     (active_s),
    .h_sync     (h_sync_s),
    .v_sync     (v_sync_s),
    .sync_n     (sync_n_s),
    .blank_n    (blank_n_s),
    .red_out    (red_s),
    .green_out  (green_s),
    .blue_out   (blue_s),
    .frame_start(frame_start_s),
    .line_start (line_start_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_50MHz);
  endtask

`ifdef TEST_PATTERN_EN
  int          tp_px  [8] = '{0, 79, 80, 159, 240, 400, 560, 639};
  logic [23:0] tp_rgb [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                              24'h00FF00, 24'hFF0000, 24'h000000, 24'h000000};
`endif

  initial begin
    int cyc, k, bh, hs_lo, hs_first, ticks, moves, n;
    int clk_hi, ls_cnt, fs_cnt, hs_cnt, vs_cnt, vs_first, late_blank;

    clear = 1'b1; enable = 1'b1; clear_s = 1'b1; enable_s = 1'b1;
`ifdef TEST_PATTERN_EN
    test_mode = 1'b0; test_mode_s = 1'b0;
`endif

    // ---------------- reset values (default mode) ----------------
    step();
    check("rst_h_sync",  h_sync, 1);
    check("rst_v_sync",  v_sync, 1);
    check("rst_blank_n", blank_n, 0);
    check("rst_sync_n",  sync_n, 0);
    check("rst_pclk",    clk_25MHz, 0);
    check("rst_tick",    pix_tick, 0);
    check("rst_fs_ls",   {frame_start, line_start}, 0);
    check("rst_rgb",     {red_out, green_out, blue_out}, 0);
    check("rst_xy",      {x, y}, 0);

    // Release at 40 ns; frame_start should show before the 2nd clock edge after it.
    step();
    clear = 1'b0;
    step();
    check("first_frame_start", frame_start, 1);
    check("first_line_start",  line_start, 1);

    // ---------------- one full line: sync width/position, blank width ----------------
    cyc = 0; k = 0; bh = 0; hs_lo = 0; hs_first = -1;
    while (k < 800 && cyc < 4000) begin
      if (pix_tick) begin
        if (blank_n) bh++;
        if (!h_sync) begin
          hs_lo++;
          if (hs_first < 0) hs_first = k;
        end
        k++;
      end
      step(); cyc++;
    end
    while (!line_start && cyc < 4000) begin step(); cyc++; end
    check("line_ticks",       k, 800);
    check("line_blank_hi",    bh, 640);
    check("line_hsync_lo",    hs_lo, 96);
    check("line_hsync_first", hs_first, 657);
    check("line_period",      cyc, 1600);

    // ---------------- enable low at h_cnt=300 (line 1) ----------------
    cyc = 0;
    while (!(x == 10'd300 && !pix_tick) && cyc < 2000) begin step(); cyc++; end
    check("hold_reach_300", x, 300);
    enable = 1'b0;
    ticks = 0; moves = 0;
    repeat (100) begin
      step();
      if (pix_tick) ticks++;
      if (x != 10'd300) moves++;
    end
    check("hold_no_tick",  ticks, 0);
    check("hold_x_moves",  moves, 0);
    check("hold_blank_n",  blank_n, 0);
    check("hold_rgb",      {red_out, green_out, blue_out}, 0);
    check("hold_h_sync",   h_sync, 1);
    check("hold_pclk",     clk_25MHz, 0);
    enable = 1'b1;
    step();
    check("resume_tick",   pix_tick, 1);
    check("resume_x_300",  x, 300);
    step();
    check("resume_x_301",  x, 301);
    check("resume_blank",  blank_n, 1);

    // ---------------- colour path: pixel (5,3), line end, blanking ----------------
    cyc = 0;
    while (!(pix_tick && x == 10'd5 && y == 10'd3) && cyc < 8000) begin step(); cyc++; end
    check("px53_prev_red", red_out, 4);
    step();
    check("px53_red",   red_out, 8'h05);
    check("px53_green", green_out, 8'h03);
    check("px53_blue",  blue_out, 8'hA5);
    cyc = 0;
    while (!(pix_tick && x == 10'd639) && cyc < 2000) begin step(); cyc++; end
    step();
    check("px639_red",   red_out, 8'h7F);
    check("px639_blank", blank_n, 1);
    step();
    cyc = 0;
    while (!pix_tick && cyc < 10) begin step(); cyc++; end
    step();
    check("hblank_blank_n", blank_n, 0);
    check("hblank_rgb",     {red_out, green_out, blue_out}, 0);

    // ---------------- clear mid-frame ----------------
    cyc = 0;
    while (!(pix_tick && x == 10'd100) && cyc < 2000) begin step(); cyc++; end
    step();
    check("pre_clear_blank", blank_n, 1);
    #2 clear = 1'b1;
    #1;
    check("clr_xy",      {x, y}, 0);
    check("clr_blank",   blank_n, 0);
    check("clr_rgb",     {red_out, green_out, blue_out}, 0);
    check("clr_syncs",   {h_sync, v_sync}, 2'b11);
    check("clr_tick",    {pix_tick, clk_25MHz, frame_start, line_start}, 0);
    step();
    clear = 1'b0;
    step();
    check("restart_frame_start", frame_start, 1);

    // ---------------- small mode: reset, first frame_start, full frame ----------------
    check("s_rst_syncs", {h_sync_s, v_sync_s}, 2'b00);
    check("s_rst_blank", blank_n_s, 0);
    clear_s = 1'b0;
    n = 0;
    while (!frame_start_s && n < 20) begin step(); n++; end
    check("s_first_fs_delay", n, 3);

    k = 0; clk_hi = 0; ls_cnt = 0; fs_cnt = 0; bh = 0; hs_cnt = 0; vs_cnt = 0;
    vs_first = -1; late_blank = 0;
    for (int c = 0; c < 1152; c++) begin
      if (clk_25_s)     clk_hi++;
      if (line_start_s) ls_cnt++;
      if (frame_start_s) fs_cnt++;
      if (pix_tick_s) begin
        if (blank_n_s) begin
          bh++;
          if (k >= 193) late_blank++;
        end
        if (h_sync_s) hs_cnt++;
        if (v_sync_s) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
        k++;
      end
      step();
    end
    check("s_frame_period",  frame_start_s, 1);
    check("s_frame_ticks",   k, 288);
    check("s_fs_count",      fs_cnt, 1);
    check("s_ls_count",      ls_cnt, 8);
    check("s_pclk_hi",       clk_hi, 576);
    check("s_blank_hi",      bh, 128);
    check("s_vblank_lines",  late_blank, 0);
    check("s_hsync_ticks",   hs_cnt, 48);
    check("s_vsync_ticks",   vs_cnt, 48);
    check("s_vsync_first",   vs_first, 217);
    check("s_sync_n",        sync_n_s, 0);

`ifdef TEST_PATTERN_EN
    // ---------------- colour bars on the default instance ----------------
    test_mode = 1'b1;
    cyc = 0;
    while (!line_start && cyc < 4000) begin step(); cyc++; end
    k = 0; cyc = 0;
    while (k <= 640 && cyc < 4000) begin
      if (pix_tick) begin
        for (int j = 0; j < 8; j++) begin
          if (tp_px[j] == k - 1)
            check($sformatf("bar_px%0d", tp_px[j]), {red_out, green_out, blue_out}, tp_rgb[j]);
        end
        k++;
      end
      step(); cyc++;
    end
    check("bar_ticks_seen", (k > 640), 1);
    test_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
